// File: rtl/keypad_scan_fifo_if.sv
// rtl/keypad_scan_fifo_if.sv - key code stream between keypad front end and its consumer
interface keypad_scan_fifo_if #(
  parameter int CW = 4
) ();
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - matrix keypad scanner with press/release debounce and key code FIFO
module keypad_scan_fifo #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 8,
  parameter int DEPTH    = 4,
  localparam int CW      = $clog2(ROWS*COLS)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [ROWS-1:0]     row_i,
  output logic [COLS-1:0]     shift_col_o,
  output logic                key_held_o,
  output logic                overflow_o,
  input  logic                clr_ovf_i,
  keypad_scan_fifo_if.master  key_if
);

  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW  = $clog2(DEBOUNCE + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  state_e          state_q, state_d;
  logic [ROWS-1:0] rs_meta_q, rs_q;
  logic [CLW-1:0]  col_q, col_d, col_inc;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   deb_q, deb_d;
  logic [BW-1:0]   rel_q, rel_d;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   code_push;
  logic            push_req;

  logic [CW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     count_q;
  logic            ovf_q;
  logic            full, pop, push_ok;

  // Rows idle high, so the synchroniser resets to all ones.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rs_meta_q <= '1;
      rs_q      <= '1;
    end else begin
      rs_meta_q <= row_i;
      rs_q      <= rs_meta_q;
    end
  end

  assign col_inc = (col_q == CLW'(COLS-1)) ? '0 : col_q + 1'b1;

  // Lowest low row wins when several rows of the column are down.
  always_comb begin
    row_idx = '0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (!pat_q[r]) row_idx = r[RW-1:0];
    end
  end

  assign code_push = CW'(int'(col_q) * ROWS + int'(row_idx));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      dwell_q <= '0;
      deb_q   <= '0;
      rel_q   <= '0;
      pat_q   <= '1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    dwell_d    = dwell_q;
    deb_d      = deb_q;
    rel_d      = rel_q;
    pat_d      = pat_q;
    push_req   = 1'b0;
    key_held_o = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DW'(SCAN_DIV-1)) begin
          if (!(&rs_q)) begin
            state_d = ST_DEBOUNCE;
            pat_d   = rs_q;
            deb_d   = '0;
          end else begin
            col_d   = col_inc;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        // The capture sample plus DEBOUNCE-1 matching samples make DEBOUNCE stable cycles.
        if (rs_q != pat_q) begin
          state_d = ST_SCAN;
          dwell_d = '0;
        end else if (deb_q == BW'(DEBOUNCE-2)) begin
          push_req = 1'b1;
          state_d  = ST_HELD;
          rel_d    = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_HELD: begin
        key_held_o = 1'b1;
        if (!(&rs_q)) begin
          rel_d = '0;
        end else if (rel_q == BW'(DEBOUNCE-1)) begin
          state_d = ST_SCAN;
          col_d   = col_inc;
          dwell_d = '0;
          rel_d   = '0;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  assign shift_col_o = ~(COLS'(1) << col_q);

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = key_if.key_valid & key_if.key_ready;
  assign push_ok = push_req & (!full | pop);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= code_push;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A dropped press outranks a clear in the same cycle.
      if (push_req && full && !pop) ovf_q <= 1'b1;
      else if (clr_ovf_i)           ovf_q <= 1'b0;
    end
  end

  assign key_if.key_valid = (count_q != '0);
  assign key_if.key_code  = mem_q[rd_q];
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb/tb_keypad_scan_fifo.sv - directed and randomized checks of keypad_scan_fifo against a queue model
module tb_keypad_scan_fifo;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 8, DEPTH = 4, CW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] shift_col;
  logic            held, ovf, clr;
  logic [15:0]     keys;

  int   n_checks = 0;
  int   n_errors = 0;
  int   q[$];
  logic exp_ovf;
  bit   held_seen = 1'b0;
  bit   mon_en = 1'b0;
  int   lat, lat_cal, dummy;

  always #5 clk = ~clk;

  keypad_scan_fifo_if #(.CW(CW)) kif ();

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .row_i       (row),
    .shift_col_o (shift_col),
    .key_held_o  (held),
    .overflow_o  (ovf),
    .clr_ovf_i   (clr),
    .key_if      (kif.master)
  );

  // Switch matrix: a closed switch pulls its row low while its column strobe is low.
  always_comb begin
    row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[c*ROWS + r] && !shift_col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (held === 1'b1) held_seen = 1'b1;
    if (reset_n && mon_en) chk("col_onehot", $countones(~shift_col), 1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input logic v, input string tag, output int cyc);
    cyc = 0;
    while (held !== v && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, held, v);
  endtask

  task automatic model_push(input int code);
    if (q.size() < DEPTH) q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, kif.key_valid, q.size() != 0);
    if (q.size() != 0) chk({tag, "_head"}, kif.key_code, q[0]);
    chk({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_valid"}, kif.key_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk({tag, "_code"}, kif.key_code, q[0]);
      void'(q.pop_front());
    end
    kif.key_ready = 1'b1;
    tick(1);
    kif.key_ready = 1'b0;
  endtask

  task automatic press_key(input int code, input int hold, output int l);
    int c2;
    keys[code] = 1'b1;
    wait_held(1'b1, "press_held", l);
    tick(hold);
    keys = '0;
    wait_held(1'b0, "release_held", c2);
    model_push(code);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    q.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq[$];
    logic [3:0] exp_seq [4];
    int         n;
    int         codes4 [5];
    int         code;

    exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    codes4  = '{0, 5, 10, 15, 4};

    reset_n = 1'b0;
    keys = '0;
    clr = 1'b0;
    kif.key_ready = 1'b0;
    exp_ovf = 1'b0;
    tick(3);
    chk("rst_col", shift_col, 4'b1110);
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_code", kif.key_code, 0);
    chk("rst_held", held, 0);
    chk("rst_ovf", ovf, 0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Single press, one entry only, consumed by one ready cycle
    keys[1] = 1'b1;
    tick(40);
    chk("t1_held", held, 1);
    chk("t1_valid", kif.key_valid, 1);
    chk("t1_code", kif.key_code, 1);
    keys = '0;
    wait_held(1'b0, "t1_release", dummy);
    model_push(1);
    check_state("t1");
    pop_one("t1_pop");
    chk("t1_empty", kif.key_valid, 0);

    // Column order up to col3, code 15, wrap after release
    do_reset();
    keys[15] = 1'b1;
    seq.push_back(shift_col);
    n = 0;
    while (held !== 1'b1 && n < 200) begin
      tick(1);
      n++;
      if (shift_col !== seq[$]) seq.push_back(shift_col);
    end
    chk("t2_seqlen", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_seq", (i < seq.size()) ? seq[i] : 4'hx, exp_seq[i]);
    tick(25);
    chk("t2_valid", kif.key_valid, 1);
    chk("t2_code", kif.key_code, 15);
    keys = '0;
    wait_held(1'b0, "t2_release", dummy);
    model_push(15);
    chk("t2_wrap", shift_col, 4'b1110);
    pop_one("t2_pop");

    // Bouncing key on col1/row2 must never be accepted
    n = 0;
    while (shift_col !== 4'b1101 && n < 100) begin
      tick(1);
      n++;
    end
    held_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      keys[6] = 1'b1;
      tick(3);
      keys[6] = 1'b0;
      tick(1);
    end
    tick(60);
    chk("t3_held_seen", held_seen, 0);
    chk("t3_valid", kif.key_valid, 0);

    // Five presses into a four-deep FIFO: fifth dropped, overflow set
    for (int i = 0; i < 5; i++) begin
      press_key(codes4[i], 10, lat);
      check_state("t4_press");
    end
    lat_cal = lat;
    chk("t4_ovf", ovf, 1);
    for (int i = 0; i < 4; i++) pop_one("t4_drain");
    chk("t4_empty", kif.key_valid, 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_ovf = 1'b0;
    chk("t4_clr", ovf, 0);

    // Full FIFO with a pop in the same cycle as the push
    for (int i = 0; i < 3; i++) press_key($urandom_range(0, 15), 10, lat);
    press_key(12 + $urandom_range(0, 3), 10, lat);
    check_state("t5_full");
    keys[4] = 1'b1;
    tick(lat_cal - 1);
    kif.key_ready = 1'b1;
    tick(1);
    kif.key_ready = 1'b0;
    void'(q.pop_front());
    model_push(4);
    chk("t5_held_now", held, 1);
    tick(10);
    keys = '0;
    wait_held(1'b0, "t5_release", dummy);
    check_state("t5");
    for (int i = 0; i < 4; i++) pop_one("t5_drain");
    chk("t5_empty", kif.key_valid, 0);

    // Random presses with random draining
    for (int i = 0; i < 8; i++) begin
      code = $urandom_range(0, 15);
      press_key(code, $urandom_range(2, 12), lat);
      check_state("rnd");
      if ($urandom_range(0, 1) == 1 && q.size() != 0) pop_one("rnd_pop");
    end

    // Reset during a debounce with entries queued
    do_reset();
    press_key(3, 8, lat);
    press_key(9, 8, lat);
    check_state("t6_queued");
    keys[0] = 1'b1;
    n = 0;
    while (shift_col !== 4'b1110 && n < 100) begin
      tick(1);
      n++;
    end
    tick(6);
    reset_n = 1'b0;
    tick(1);
    chk("t6_valid", kif.key_valid, 0);
    chk("t6_col", shift_col, 4'b1110);
    chk("t6_held", held, 0);
    chk("t6_ovf", ovf, 0);
    keys = '0;
    q.delete();
    exp_ovf = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(100);
    chk("t6_no_stale", kif.key_valid, 0);
    chk("t6_held_after", held, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
